pll_param_readback: RTL

//  Reader side of the PLL reconfiguration path: on trigger, reads back M and N counter settings

---
 rtl/pll_param_readback_if.sv | 26 ++
 rtl/pll_param_readback.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pll_param_readback_if.sv
// Read-parameter port of the PLL reconfiguration controller.
// master: the readback engine (issues requests, selects counter/parameter).
// slave : the reconfiguration controller (returns busy and read data).
interface pll_param_readback_if;
  logic       rcfg_read_param;
  logic [3:0] rcfg_counter_type;
  logic [2:0] rcfg_counter_param;
  logic       rcfg_busy;
  logic [8:0] rcfg_data_out;

  modport master (
    output rcfg_read_param,
    output rcfg_counter_type,
    output rcfg_counter_param,
    input  rcfg_busy,
    input  rcfg_data_out
  );

  modport slave (
    input  rcfg_read_param,
    input  rcfg_counter_type,
    input  rcfg_counter_param,
    output rcfg_busy,
    output rcfg_data_out
  );
endinterface

// File: rtl/pll_param_readback.sv
// PLL parameter readback: on trigger, reads M/N high, low and bypass
// settings through the reconfig controller read port, rebuilds the
// effective multiply/divide factors and reports them with a done pulse.
// Optional feature macro: PLL_READBACK_CMP_EN (compare against exp_data).
module pll_param_readback #(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [3:0] CNT_TYPE_N     = 4'b0000,
  parameter logic [3:0] CNT_TYPE_M     = 4'b0001
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    trigger,
  input  logic [15:0]             exp_data,
  pll_param_readback_if.master    rcfg,
  output logic                    busy,
  output logic                    done,
  output logic [9:0]              mult_factor,
  output logic [9:0]              div_factor,
  output logic                    timeout_err,
  output logic                    match
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_RISE, S_WAIT_FALL, S_CAPTURE, S_EVAL, S_ERR
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic [2:0]    idx;
  logic [7:0]    m_hi, m_lo, n_hi, n_lo;
  logic          m_byp, n_byp;
  logic          accept;
  logic          rd_active;

  // A programmed count of 0 means 256 divider steps.
  function automatic logic [9:0] cnt_ext(input logic [7:0] c);
    return (c == 8'h00) ? 10'd256 : {2'b00, c};
  endfunction

  function automatic logic [9:0] factor(input logic [7:0] hi, input logic [7:0] lo,
                                        input logic byp);
    return byp ? 10'd1 : (cnt_ext(hi) + cnt_ext(lo));
  endfunction

  assign accept = (state == S_IDLE) && (state_nxt == S_ISSUE);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; busy is checked before the timeout so a late edge still wins.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (trigger && !rcfg.rcfg_busy) state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = S_WAIT_RISE;
      S_WAIT_RISE: if (rcfg.rcfg_busy) state_nxt = S_WAIT_FALL;
                   else if (timer >= TW'(TIMEOUT_CYCLES)) state_nxt = S_ERR;
      S_WAIT_FALL: if (!rcfg.rcfg_busy) state_nxt = S_CAPTURE;
                   else if (timer >= TW'(TIMEOUT_CYCLES)) state_nxt = S_ERR;
      S_CAPTURE:   state_nxt = (idx == 3'd5) ? S_EVAL : S_ISSUE;
      S_EVAL:      state_nxt = S_IDLE;
      S_ERR:       state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Read port drive: counter/parameter select is held from ISSUE through CAPTURE.
  always_comb begin
    rcfg.rcfg_read_param    = (state == S_ISSUE);
    rcfg.rcfg_counter_type  = 4'b0000;
    rcfg.rcfg_counter_param = 3'b000;
    rd_active = (state == S_ISSUE) || (state == S_WAIT_RISE) ||
                (state == S_WAIT_FALL) || (state == S_CAPTURE);
    if (rd_active) begin
      rcfg.rcfg_counter_type = (idx < 3'd3) ? CNT_TYPE_M : CNT_TYPE_N;
      case (idx)
        3'd0, 3'd3: rcfg.rcfg_counter_param = 3'b000;
        3'd1, 3'd4: rcfg.rcfg_counter_param = 3'b001;
        default:    rcfg.rcfg_counter_param = 3'b100;
      endcase
    end
  end

  // Per-state timer, cleared on every state change.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                timer <= '0;
    else if (state_nxt != state) timer <= '0;
    else if (timer != '1)        timer <= timer + 1'b1;
  end

  // Read index and captured counter settings.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx   <= 3'd0;
      m_hi  <= 8'h00;
      m_lo  <= 8'h00;
      m_byp <= 1'b0;
      n_hi  <= 8'h00;
      n_lo  <= 8'h00;
      n_byp <= 1'b0;
    end else if (accept) begin
      idx <= 3'd0;
    end else if (state == S_CAPTURE) begin
      case (idx)
        3'd0:    m_hi  <= rcfg.rcfg_data_out[7:0];
        3'd1:    m_lo  <= rcfg.rcfg_data_out[7:0];
        3'd2:    m_byp <= rcfg.rcfg_data_out[0];
        3'd3:    n_hi  <= rcfg.rcfg_data_out[7:0];
        3'd4:    n_lo  <= rcfg.rcfg_data_out[7:0];
        default: n_byp <= rcfg.rcfg_data_out[0];
      endcase
      idx <= idx + 3'd1;
    end
  end

  // Status and result outputs; factors change only when a sequence completes cleanly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      mult_factor <= 10'd0;
      div_factor  <= 10'd0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        busy        <= 1'b1;
        timeout_err <= 1'b0;
      end else if (state == S_EVAL) begin
        busy        <= 1'b0;
        done        <= 1'b1;
        mult_factor <= factor(m_hi, m_lo, m_byp);
        div_factor  <= factor(n_hi, n_lo, n_byp);
      end else if (state == S_ERR) begin
        busy        <= 1'b0;
        done        <= 1'b1;
        timeout_err <= 1'b1;
      end
    end
  end

`ifdef PLL_READBACK_CMP_EN
  logic [15:0] exp_q;

  // Expected word is captured at trigger accept and compared when factors are rebuilt.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_q <= 16'h0000;
      match <= 1'b0;
    end else if (accept) begin
      exp_q <= exp_data;
      match <= 1'b0;
    end else if (state == S_EVAL) begin
      match <= (factor(m_hi, m_lo, m_byp) == {2'b00, exp_q[15:8]}) &&
               (factor(n_hi, n_lo, n_byp) == {2'b00, exp_q[7:0]});
    end else if (state == S_ERR) begin
      match <= 1'b0;
    end
  end
`else
  logic unused_exp;
  assign unused_exp = ^exp_data;
  assign match      = 1'b0;
`endif

endmodule
